// File: rtl/aes_ctrl_pkg.sv
// Shared AES control definitions: instruction field layout and unit IDs.
// Used by the request queue, the AES FSM and the completion queue.
package aes_ctrl_pkg;

    localparam int ADDRW     = 24;
    localparam int MODE_BIT  = 3*ADDRW+1;
    localparam int RSVD_BIT  = 3*ADDRW;
    localparam int KEY_MSB   = 3*ADDRW-1;
    localparam int KEY_LSB   = 2*ADDRW;
    localparam int TEXT_MSB  = 2*ADDRW-1;
    localparam int TEXT_LSB  = ADDRW;
    localparam int DEST_MSB  = ADDRW-1;
    localparam int DEST_LSB  = 0;

    localparam logic [1:0] MEM_ID   = 2'b00;
    localparam logic [1:0] ACCEL_ID = 2'b10;

endpackage

// File: rtl/aes_req_queue.sv
// AES instruction request queue: circular buffer between the CPU register
// interface and the AES control FSM, with occupancy, sticky overflow and flush.
module aes_req_queue #(
    parameter int ADDRW = aes_ctrl_pkg::ADDRW,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH)+1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [3*ADDRW+1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [3*ADDRW+1:0] out_data,
    input  logic               out_ready,
    input  logic               flush,
    input  logic               clr_overflow,
    output logic [CW-1:0]      count,
    output logic               overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = 3*ADDRW+2;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_drop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid & ~w_full;
    assign w_pop   = ~w_empty & out_ready;
    assign w_drop  = in_valid & w_full;

    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign out_data  = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign overflow  = r_overflow;

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A dropped push outranks a same-cycle clear so no loss goes unreported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_req_queue.sv
// Directed testbench for aes_req_queue with hand-computed expectations.
module tb_aes_req_queue;

    localparam int ADDRW = 24;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int DW    = 3*ADDRW+2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          flush;
    logic          clr_overflow;
    logic [CW-1:0] count;
    logic          overflow;

    int n_cmp;
    int n_bad;

    aes_req_queue #(
        .ADDRW(ADDRW),
        .DEPTH(DEPTH),
        .CW   (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .flush       (flush),
        .clr_overflow(clr_overflow),
        .count       (count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic m, input logic r,
                                         input logic [23:0] k,
                                         input logic [23:0] t,
                                         input logic [23:0] d);
        return {m, r, k, t, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        flush = 1'b0;
        clr_overflow = 1'b0;
        #12;
        n_cmp++;
        if ({in_ready, out_valid, count, overflow} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset: got rdy=%b vld=%b cnt=%0d ovf=%b want 1 0 0 0",
                     in_ready, out_valid, count, overflow);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        d = mk(1'b1, 1'b0, 24'h000100, 24'h000200, 24'h000300);
        in_valid = 1'b1;
        in_data = d;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, count} !== {1'b1, 3'd1} || out_data !== d) begin
            n_bad++;
            $display("FAIL single_push: got vld=%b cnt=%0d data=%h want 1 1 %h",
                     out_valid, count, out_data, d);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, count} !== {1'b0, 3'd0}) begin
            n_bad++;
            $display("FAIL single_pop: got vld=%b cnt=%0d want 0 0", out_valid, count);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] e [5];
        for (int i = 0; i < 5; i++) begin
            e[i] = mk(i[0], i[1], 24'h100000 + 24'(i), 24'h200000 + 24'(i),
                      24'h300000 + 24'(i));
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = e[i];
            tick();
        end
        n_cmp++;
        if ({count, in_ready, overflow} !== {3'd4, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL fill: got cnt=%0d rdy=%b ovf=%b want 4 0 0",
                     count, in_ready, overflow);
        end
        in_data = e[4];
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({count, overflow} !== {3'd4, 1'b1} || out_data !== e[0]) begin
            n_bad++;
            $display("FAIL drop5: got cnt=%0d ovf=%b head=%h want 4 1 %h",
                     count, overflow, out_data, e[0]);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== e[i]) begin
                n_bad++;
                $display("FAIL drain[%0d]: got vld=%b data=%h want 1 %h",
                         i, out_valid, out_data, e[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, count} !== {1'b0, 3'd0}) begin
            n_bad++;
            $display("FAIL drain_end: got vld=%b cnt=%0d want 0 0", out_valid, count);
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_ovf: got %b want 0", overflow);
        end
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] f [6];
        for (int i = 0; i < 6; i++) begin
            f[i] = mk(1'b1, 1'b1, 24'hABC000 + 24'(i), 24'h00F000 + 24'(i),
                      24'h0000F0 + 24'(i));
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = f[i];
            tick();
        end
        in_data = f[4];
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if ({count, overflow, in_ready} !== {3'd3, 1'b1, 1'b1} || out_data !== f[1]) begin
            n_bad++;
            $display("FAIL full_pop: got cnt=%0d ovf=%b rdy=%b head=%h want 3 1 1 %h",
                     count, overflow, in_ready, out_data, f[1]);
        end
        in_valid = 1'b1;
        in_data = f[5];
        tick();
        clr_overflow = 1'b1;
        in_data = f[0];
        tick();
        in_valid = 1'b0;
        clr_overflow = 1'b0;
        n_cmp++;
        if ({count, overflow} !== {3'd4, 1'b1}) begin
            n_bad++;
            $display("FAIL set_wins: got cnt=%0d ovf=%b want 4 1", count, overflow);
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] w;
            w = (i == 3) ? f[5] : f[i+1];
            n_cmp++;
            if (out_data !== w || overflow !== 1'b0) begin
                n_bad++;
                $display("FAIL fp_drain[%0d]: got data=%h ovf=%b want %h 0",
                         i, out_data, overflow, w);
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [DW-1:0] s [11];
        for (int i = 0; i < 11; i++) begin
            s[i] = mk(i[0], ~i[0], 24'h5A0000 + 24'(i), 24'h00A500 + 24'(i),
                      24'h0000C0 + 24'(i));
        end
        in_valid = 1'b1;
        in_data = s[0];
        tick();
        out_ready = 1'b1;
        for (int i = 1; i < 11; i++) begin
            in_data = s[i];
            n_cmp++;
            if (out_data !== s[i-1] || count !== 3'd1) begin
                n_bad++;
                $display("FAIL stream[%0d]: got data=%h cnt=%0d want %h 1",
                         i, out_data, count, s[i-1]);
            end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (out_data !== s[10] || count !== 3'd1) begin
            n_bad++;
            $display("FAIL stream_last: got data=%h cnt=%0d want %h 1",
                     out_data, count, s[10]);
        end
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (count !== 3'd0) begin
            n_bad++;
            $display("FAIL stream_end: got cnt=%0d want 0", count);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] g;
        g = mk(1'b0, 1'b1, 24'h123456, 24'h789ABC, 24'hDEF012);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = mk(1'b1, 1'b0, 24'(i), 24'(i), 24'(i));
            tick();
        end
        in_data = mk(1'b1, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        n_cmp++;
        if ({count, out_valid, in_ready, overflow} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL flush: got cnt=%0d vld=%b rdy=%b ovf=%b want 0 0 1 0",
                     count, out_valid, in_ready, overflow);
        end
        in_valid = 1'b1;
        in_data = g;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (count !== 3'd1 || out_data !== g) begin
            n_bad++;
            $display("FAIL post_flush: got cnt=%0d data=%h want 1 %h", count, out_data, g);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [DW-1:0] h;
        h = mk(1'b1, 1'b0, 24'hC0FFEE, 24'hBADA55, 24'h0DDBA1);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = mk(1'b0, 1'b0, 24'h7 + 24'(i), 24'h8, 24'h9);
            tick();
        end
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL async_rst: got vld=%b cnt=%0d rdy=%b want 0 0 1",
                     out_valid, count, in_ready);
        end
        #2;
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data = h;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, count} !== {1'b1, 3'd1} || out_data !== h) begin
            n_bad++;
            $display("FAIL after_rst: got vld=%b cnt=%0d data=%h want 1 1 %h",
                     out_valid, count, out_data, h);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_stream();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
